// File: rtl/vc_mode_counter.sv
// Up/down counter with programmable step, runtime limit, direct load and saturate-or-wrap mode.
// Latency: count and flags are registered, so an operation shows up one cycle later; no backpressure.
module vc_mode_counter #(
    parameter int p_count_nbits       = 8,
    parameter int p_step_nbits        = 4,
    parameter int p_count_clear_value = 0,
    parameter bit p_wrap              = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     load,
    input  logic [p_count_nbits-1:0] load_value,
    input  logic                     increment,
    input  logic                     decrement,
    input  logic [p_step_nbits-1:0]  step,
    input  logic [p_count_nbits-1:0] limit,
    output logic [p_count_nbits-1:0] count,
    output logic                     count_is_zero,
    output logic                     count_is_max,
    output logic                     wrap_pulse,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int lp_w = p_count_nbits + 1;
    localparam logic [p_count_nbits-1:0] lp_clear = p_count_clear_value[p_count_nbits-1:0];

    logic [p_count_nbits-1:0] r_count;
    logic                     r_overflow;
    logic                     r_underflow;
    logic                     r_wrap_pulse;

    logic [p_count_nbits-1:0] w_count_nxt;
    logic                     w_ovf_set;
    logic                     w_unf_set;
    logic                     w_wrap_evt;

    // Widened by one bit so limit+1 stays exact when limit is all-ones.
    logic [lp_w-1:0] w_cnt_x;
    logic [lp_w-1:0] w_lim_x;
    logic [lp_w-1:0] w_lim1;
    logic [lp_w-1:0] w_step_x;
    logic [lp_w-1:0] w_step_eff;
    logic [lp_w-1:0] w_sum;

    assign w_cnt_x    = {1'b0, r_count};
    assign w_lim_x    = {1'b0, limit};
    assign w_lim1     = w_lim_x + lp_w'(1);
    assign w_step_x   = {{(lp_w - p_step_nbits){1'b0}}, step};
    assign w_step_eff = (p_wrap && (w_step_x > w_lim1)) ? w_lim1 : w_step_x;
    assign w_sum      = w_cnt_x + w_step_eff;

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_wrap_evt  = 1'b0;
        if (load) begin
            if (load_value <= limit) begin
                w_count_nxt = load_value;
            end else begin
                w_count_nxt = limit;
                w_ovf_set   = 1'b1;
            end
        end else if (r_count > limit) begin
            w_count_nxt = limit;
            w_ovf_set   = 1'b1;
        end else if ((increment ^ decrement) && (step != '0)) begin
            if (increment) begin
                if (w_sum <= w_lim_x) begin
                    w_count_nxt = w_sum[p_count_nbits-1:0];
                end else if (p_wrap) begin
                    w_count_nxt = p_count_nbits'(w_sum - w_lim1);
                    w_wrap_evt  = 1'b1;
                end else begin
                    w_count_nxt = limit;
                    w_ovf_set   = 1'b1;
                end
            end else begin
                if (w_step_eff <= w_cnt_x) begin
                    w_count_nxt = p_count_nbits'(w_cnt_x - w_step_eff);
                end else if (p_wrap) begin
                    w_count_nxt = p_count_nbits'(w_cnt_x + w_lim1 - w_step_eff);
                    w_wrap_evt  = 1'b1;
                end else begin
                    w_count_nxt = '0;
                    w_unf_set   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count      <= lp_clear;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_overflow   <= r_overflow | w_ovf_set;
            r_underflow  <= r_underflow | w_unf_set;
            r_wrap_pulse <= w_wrap_evt;
        end
    end

    assign count         = r_count;
    assign count_is_zero = (r_count == '0);
    assign count_is_max  = (r_count == limit);
    assign wrap_pulse    = r_wrap_pulse;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    a_ctrl_known : assert property (@(posedge clk) disable iff (reset)
        !$isunknown({increment, decrement, load, clear}));

endmodule

// File: tb/tb_vc_mode_counter.sv
// Bench for vc_mode_counter: a saturating and a wrapping instance share stimulus and are
// checked every cycle against an integer model, plus directed literal checks.
module tb_vc_mode_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       increment = 1'b0;
    logic       decrement = 1'b0;
    logic [3:0] step = '0;
    logic [7:0] limit = 8'd255;

    logic [7:0] cnt_o [2];
    logic [1:0] zero_o, max_o, wp_o, ovf_o, unf_o;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vc_mode_counter #(.p_count_nbits(8), .p_step_nbits(4), .p_count_clear_value(3), .p_wrap(1'b0)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .increment(increment), .decrement(decrement), .step(step), .limit(limit),
        .count(cnt_o[0]), .count_is_zero(zero_o[0]), .count_is_max(max_o[0]),
        .wrap_pulse(wp_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

    vc_mode_counter #(.p_count_nbits(8), .p_step_nbits(4), .p_count_clear_value(3), .p_wrap(1'b1)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .increment(increment), .decrement(decrement), .step(step), .limit(limit),
        .count(cnt_o[1]), .count_is_zero(zero_o[1]), .count_is_max(max_o[1]),
        .wrap_pulse(wp_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

    // Reference model: index 0 saturates, index 1 wraps modulo (limit+1).
    int m_cnt [2];
    bit m_ovf [2];
    bit m_unf [2];
    bit m_wp  [2];
    int mc, mm, ms, mlim;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mc   = m_cnt[i];
            mlim = int'(limit);
            if (reset || clear) begin
                m_cnt[i] = 3;
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
                m_wp[i]  = 1'b0;
            end else begin
                m_wp[i] = 1'b0;
                if (load) begin
                    if (int'(load_value) <= mlim) mc = int'(load_value);
                    else begin mc = mlim; m_ovf[i] = 1'b1; end
                end else if (mc > mlim) begin
                    mc = mlim;
                    m_ovf[i] = 1'b1;
                end else if ((increment != decrement) && (step != 0)) begin
                    mm = mlim + 1;
                    ms = int'(step);
                    if (i == 1 && ms > mm) ms = mm;
                    if (increment) begin
                        if (mc + ms <= mlim) mc = mc + ms;
                        else if (i == 0) begin mc = mlim; m_ovf[i] = 1'b1; end
                        else begin mc = (mc + ms) % mm; m_wp[i] = 1'b1; end
                    end else begin
                        if (ms <= mc) mc = mc - ms;
                        else if (i == 0) begin mc = 0; m_unf[i] = 1'b1; end
                        else begin mc = (((mc - ms) % mm) + mm) % mm; m_wp[i] = 1'b1; end
                    end
                end
                m_cnt[i] = mc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                n_chk += 6;
                if (int'(cnt_o[i]) != m_cnt[i]) begin
                    n_fail++;
                    $display("FAIL count[%0d] t=%0t got %0d want %0d", i, $time, cnt_o[i], m_cnt[i]);
                end
                if (zero_o[i] != (m_cnt[i] == 0)) begin
                    n_fail++;
                    $display("FAIL count_is_zero[%0d] t=%0t got %0b want %0b", i, $time, zero_o[i], m_cnt[i] == 0);
                end
                if (max_o[i] != (m_cnt[i] == int'(limit))) begin
                    n_fail++;
                    $display("FAIL count_is_max[%0d] t=%0t got %0b want %0b", i, $time, max_o[i], m_cnt[i] == int'(limit));
                end
                if (wp_o[i] != m_wp[i]) begin
                    n_fail++;
                    $display("FAIL wrap_pulse[%0d] t=%0t got %0b want %0b", i, $time, wp_o[i], m_wp[i]);
                end
                if (ovf_o[i] != m_ovf[i]) begin
                    n_fail++;
                    $display("FAIL overflow[%0d] t=%0t got %0b want %0b", i, $time, ovf_o[i], m_ovf[i]);
                end
                if (unf_o[i] != m_unf[i]) begin
                    n_fail++;
                    $display("FAIL underflow[%0d] t=%0t got %0b want %0b", i, $time, unf_o[i], m_unf[i]);
                end
            end
        end
    end

    task automatic cyc(input bit r, input bit c, input bit ld, input int lv,
                       input bit inc, input bit dec, input int st, input int lim);
        #1;
        reset      = r;
        clear      = c;
        load       = ld;
        load_value = 8'(lv);
        increment  = inc;
        decrement  = dec;
        step       = 4'(st);
        limit      = 8'(lim);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    int cur_lim;
    bit r_r, r_c, r_l, r_i, r_d;

    initial begin
        // reset, load, clear
        cyc(1, 0, 0, 0, 0, 0, 0, 255);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 255);
        chk("reset_count", int'(cnt_o[0]), 3);
        chk("reset_ovf", int'(ovf_o[0]), 0);
        chk("reset_wp", int'(wp_o[1]), 0);
        cyc(0, 0, 1, 7, 0, 0, 0, 10);
        chk("load7", int'(cnt_o[0]), 7);
        cyc(0, 1, 0, 0, 0, 0, 0, 10);
        chk("clear", int'(cnt_o[0]), 3);
        chk("clear_unf", int'(unf_o[0]), 0);
        // saturate up
        cyc(0, 0, 1, 8, 0, 0, 0, 10);
        cyc(0, 0, 0, 0, 1, 0, 4, 10);
        chk("sat_up_count", int'(cnt_o[0]), 10);
        chk("sat_up_ovf", int'(ovf_o[0]), 1);
        chk("sat_up_wp", int'(wp_o[0]), 0);
        cyc(0, 0, 0, 0, 1, 0, 4, 10);
        chk("sat_up_hold", int'(cnt_o[0]), 10);
        // wrap up then down
        cyc(0, 1, 0, 0, 0, 0, 0, 9);
        cyc(0, 0, 1, 8, 0, 0, 0, 9);
        cyc(0, 0, 0, 0, 1, 0, 3, 9);
        chk("wrap_up_count", int'(cnt_o[1]), 1);
        chk("wrap_up_wp", int'(wp_o[1]), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 9);
        chk("wrap_wp_one_cycle", int'(wp_o[1]), 0);
        cyc(0, 0, 0, 0, 0, 1, 3, 9);
        chk("wrap_dn_count", int'(cnt_o[1]), 8);
        chk("wrap_dn_wp", int'(wp_o[1]), 1);
        // simultaneous inc/dec and zero step
        cyc(0, 1, 0, 0, 0, 0, 0, 10);
        cyc(0, 0, 1, 4, 0, 0, 0, 10);
        cyc(0, 0, 0, 0, 1, 1, 5, 10);
        chk("both_hold", int'(cnt_o[0]), 4);
        chk("both_noovf", int'(ovf_o[0]), 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 10);
        chk("step0_hold", int'(cnt_o[1]), 4);
        // limit lowered below count
        cyc(0, 0, 1, 12, 0, 0, 0, 15);
        cyc(0, 0, 0, 0, 1, 0, 1, 6);
        chk("clamp_count", int'(cnt_o[0]), 6);
        chk("clamp_ovf", int'(ovf_o[0]), 1);
        chk("clamp_max", int'(max_o[0]), 1);
        cyc(0, 0, 1, 20, 0, 0, 0, 6);
        chk("load_over", int'(cnt_o[1]), 6);
        // underflow
        cyc(0, 1, 0, 0, 0, 0, 0, 10);
        cyc(0, 0, 1, 2, 0, 0, 0, 10);
        cyc(0, 0, 0, 0, 0, 1, 5, 10);
        chk("unf_count", int'(cnt_o[0]), 0);
        chk("unf_flag", int'(unf_o[0]), 1);
        chk("unf_zero", int'(zero_o[0]), 1);
        chk("wrap_dn_borrow", int'(cnt_o[1]), 8);
        // all-ones limit
        cyc(0, 0, 1, 250, 0, 0, 0, 255);
        cyc(0, 0, 0, 0, 1, 0, 10, 255);
        chk("lim255_wrap", int'(cnt_o[1]), 4);
        chk("lim255_sat", int'(cnt_o[0]), 255);
        // oversized step in wrap mode behaves as limit+1
        cyc(0, 0, 1, 2, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 1, 0, 9, 3);
        chk("bigstep_count", int'(cnt_o[1]), 2);
        chk("bigstep_wp", int'(wp_o[1]), 1);

        cur_lim = 200;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 2))
                    0: cur_lim = 255;
                    1: cur_lim = $urandom_range(0, 15);
                    default: cur_lim = $urandom_range(0, 255);
                endcase
            end
            r_r = ($urandom_range(0, 199) == 0);
            r_c = ($urandom_range(0, 29) == 0);
            r_l = ($urandom_range(0, 11) == 0);
            r_i = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            r_d = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                r_i = ~r_i;
                r_d = ~r_d;
            end
            cyc(r_r, r_c, r_l, $urandom_range(0, 255), r_i, r_d, $urandom_range(0, 15), cur_lim);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
